seq_frac_divider: RTL and testbench
===================================

// Module: seq_frac_divider
// PURPOSE
//  Sequential, parametrised unsigned fractional divider: W-bit a / W-bit b -> W integer + F fractional quotient bits.
//  Radix-2 restoring division, one quotient bit per clock, so a large combinational chain becomes a small iterative datapath.
//  Valid/ready on input and output; sits beside the ALU as a multi-cycle functional unit.
// PARAMETERS
//  W  8  operand width (a, b, integer quotient bits, remainder)
//  F  4  fractional quotient bits; F >= 0
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands offered
//  in_ready   out  1      unit idle, can accept operands
//  a          in   W      dividend (unsigned)
//  b          in   W      divisor (unsigned)
//  out_valid  out  1      result available; held until accepted
//  out_ready  in   1      consumer accepts result
//  quotient   out  W+F    floor(a*2^F / b), fixed point W.F
//  remainder  out  W      (a*2^F) mod b
//  div_by_zero out 1      b was 0 for this result
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1 after reset deassert; out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration count=0.
//  FSM: IDLE -> RUN on in_valid&&in_ready (b!=0); IDLE -> DONE on accept with b==0; RUN -> DONE after last iteration; DONE -> IDLE on out_valid&&out_ready.
//  in_ready = (state==IDLE); out_valid = (state==DONE). No new accept in the DONE cycle; back-to-back throughput is one op per N+2 cycles.
//  Accept captures a, b, zeroes a W+1-bit partial remainder, sets count=N-1 (N = W+F).
//  RUN, each cycle: partial = {partial[W-1:0], next dividend bit}; dividend bits a[W-1..0], then F zeros.
//   trial = partial - {1'b0,b} in W+2 bits; if trial sign==0 partial=trial, qbit=1 else partial kept, qbit=0.
//   qbit shifted into quotient LSB. count decrements; leaves RUN when count==0 at that edge.
//  Latency: out_valid rises N cycles after the accepting edge (edge k accept -> DONE visible after edge k+N).
//  Results stable while out_valid=1 and out_ready=0 (backpressure); values held after handshake until next result.
//  b==0: no iterations; DONE next cycle; quotient all ones, remainder=a, div_by_zero=1.
//  a==0: normal run, quotient 0, remainder 0. b==1: quotient = a<<F exactly.
//  in_valid while busy ignored (not captured); upstream must hold operands until in_ready.
//  rst mid-RUN or in DONE: operation aborted, result discarded, all outputs to reset values next edge.
// CONFIGURATION
//  `define SEQ_FRAC_DIV_ROUND_EN:
//   with: one extra guard iteration (N+1 cycles); quotient = truncated + guard bit (round half up);
//         remainder = partial after iteration N (pre-guard, shadow reg). No overflow possible: for b>=2 rounded value < 2^(W+F); b==1 guard=0.
//   without: truncating quotient, N-cycle latency, no guard/shadow logic.
//   div_by_zero result identical in both builds.
// STRUCTURE
//  Package seq_frac_divider_pkg: state_t enum {IDLE, RUN, DONE}; function count_width(W,F) = $clog2(W+F+1).
//  Sub-module frac_div_step: combinational single restoring step (partial_in, b, bit_in -> partial_out, qbit), width param W.
//  Top: FSM, count, operand/quotient shift regs, output regs, optional guard logic.
// TESTING (W=4, F=4 unless noted)
//  a=7,b=2 -> quotient 0x38 (3.5), remainder 0, out_valid 8 cycles after accept.
//  a=1,b=3 -> 0x05, rem 1; a=2,b=3 -> 0x0A rem 2 (ROUND_EN: 0x0B, 9-cycle latency).
//  a=15,b=1 -> 0xF0 rem 0; a=0,b=9 -> 0x00 rem 0.
//  b=0,a=6 -> next cycle out_valid, quotient 0xFF, rem 6, div_by_zero=1; following op clears flag.
//  Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0; in_valid pulses ignored; release -> in_ready=1 next cycle.
//  rst asserted mid-RUN (cycle 3) -> next edge out_valid=0, in_ready=1, quotient 0; new op a=9,b=4 -> 0x24 rem 0.

Source files
------------

// File: rtl/seq_frac_divider_pkg.sv
// Purpose: shared types and sizing helpers for the sequential fractional divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t      - controller states IDLE / RUN / DONE
//   count_width  - bits needed to hold an iteration count of 0..W+F
package seq_frac_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sized for W+F+1 values so the optional guard iteration (count starts at N) also fits.
    function automatic int count_width(input int w, input int f);
        return $clog2(w + f + 1);
    endfunction

endpackage

// File: rtl/frac_div_step.sv
// Purpose: one combinational radix-2 restoring division step.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   partial_in  [W:0]  partial remainder before this step
//   b           [W-1:0] divisor
//   bit_in              next dividend bit shifted into the partial remainder
//   partial_out [W:0]  partial remainder after this step
//   qbit                quotient bit produced by this step
module frac_div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   partial_in,
    input  logic [W-1:0] b,
    input  logic         bit_in,
    output logic [W:0]   partial_out,
    output logic         qbit
);

    // The partial remainder is always below b, so its MSB is zero and the
    // shifted value fits in W+1 bits; the extra top bit carries the trial sign.
    logic [W+1:0] shifted;
    logic [W+1:0] trial;

    assign shifted = {partial_in, bit_in};
    assign trial   = shifted - {2'b00, b};

    always_comb begin
        partial_out = shifted[W:0];
        qbit        = 1'b0;
        if (!trial[W+1]) begin
            partial_out = trial[W:0];
            qbit        = 1'b1;
        end
    end

endmodule

// File: rtl/seq_frac_divider.sv
// Purpose: iterative unsigned divider, a / b -> W.F fixed-point quotient plus remainder.
// Latency: W+F cycles from accept to out_valid (W+F+1 with rounding); 1 cycle when b==0.
// Backpressure: result held while out_valid && !out_ready; no new accept until result taken.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready, a, b  operand handshake (in_ready high only when idle)
//   out_valid/out_ready      result handshake
//   quotient [W+F-1:0]       floor(a*2^F / b), or rounded half-up when SEQ_FRAC_DIV_ROUND_EN
//   remainder [W-1:0]        (a*2^F) mod b
//   div_by_zero              b was zero: quotient all ones, remainder = a
//
// Build option: define SEQ_FRAC_DIV_ROUND_EN to add one guard iteration and round half up.
module seq_frac_divider
    import seq_frac_divider_pkg::*;
#(
    parameter int W = 8,
    parameter int F = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+F-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int N  = W + F;
    localparam int CW = count_width(W, F);
`ifdef SEQ_FRAC_DIV_ROUND_EN
    localparam int ITERS = N + 1;
`else
    localparam int ITERS = N;
`endif
    localparam logic [CW-1:0] CNT_START = CW'(ITERS - 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic [W-1:0]    dvd_sh;   // dividend bits, MSB first; zeros fill in for the fraction
    logic [W-1:0]    b_r;
    logic [W:0]      partial;
    logic [N-1:0]    quo;
`ifdef SEQ_FRAC_DIV_ROUND_EN
    logic [W-1:0]    rem_shadow; // remainder after the last real iteration, before the guard
`endif

    logic [W:0]      step_partial;
    logic            step_qbit;

    frac_div_step #(.W(W)) u_step (
        .partial_in  (partial),
        .b           (b_r),
        .bit_in      (dvd_sh[W-1]),
        .partial_out (step_partial),
        .qbit        (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            dvd_sh      <= '0;
            b_r         <= '0;
            partial     <= '0;
            quo         <= '0;
`ifdef SEQ_FRAC_DIV_ROUND_EN
            rem_shadow  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (b == '0) begin
                            // No iterations: result is defined directly.
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                        end else begin
                            state   <= RUN;
                            dvd_sh  <= a;
                            b_r     <= b;
                            partial <= '0;
                            quo     <= '0;
                            count   <= CNT_START;
                        end
                    end
                end

                RUN: begin
                    dvd_sh  <= dvd_sh << 1;
                    partial <= step_partial;
                    count   <= count - CW'(1);
`ifdef SEQ_FRAC_DIV_ROUND_EN
                    // The final (count==0) step is the guard: its qbit rounds, it is not a quotient bit.
                    if (count != '0) begin
                        quo <= (quo << 1) | N'(step_qbit);
                    end
                    if (count == CW'(1)) begin
                        rem_shadow <= step_partial[W-1:0];
                    end
                    if (count == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= quo + N'(step_qbit);
                        remainder   <= rem_shadow;
                        div_by_zero <= 1'b0;
                    end
`else
                    quo <= (quo << 1) | N'(step_qbit);
                    if (count == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= (quo << 1) | N'(step_qbit);
                        remainder   <= step_partial[W-1:0];
                        div_by_zero <= 1'b0;
                    end
`endif
                end

                DONE: begin
                    // Output registers keep the result after the handshake until the next one lands.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frac_divider.sv
// Purpose: self-checking bench for seq_frac_divider at W=4, F=4.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and ignored in_valid while busy.
module tb_seq_frac_divider;

    localparam int W = 4;
    localparam int F = 4;
    localparam int N = W + F;
`ifdef SEQ_FRAC_DIV_ROUND_EN
    localparam int LAT = N + 1;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = N;
    localparam bit RND = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W+F-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    seq_frac_divider #(.W(W), .F(F)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Arithmetic reference for a completed division.
    function automatic int ref_quot(input int x, input int y);
        int q;
        q = (x << F) / y;
        if (RND) q = q + (((x << (F + 1)) / y) & 1);
        return q;
    endfunction

    function automatic int ref_rem(input int x, input int y);
        return (x << F) % y;
    endfunction

    // Transaction-level model: idle / busy for LAT cycles / holding a result.
    int             m_phase = 0;   // 0 idle, 1 busy, 2 result pending
    int             m_wait = 0;
    int             m_a = 0;
    int             m_b = 0;
    logic [W+F-1:0] m_q = '0;
    logic [W-1:0]   m_r = '0;
    logic           m_dbz = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_q = '0;
            m_r = '0;
            m_dbz = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    if (b == 0) begin
                        m_phase = 2;
                        m_q = '1;
                        m_r = a;
                        m_dbz = 1'b1;
                    end else begin
                        m_phase = 1;
                        m_wait = LAT;
                        m_a = int'(a);
                        m_b = int'(b);
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_phase = 2;
                        m_q = (W+F)'(ref_quot(m_a, m_b));
                        m_r = W'(ref_rem(m_a, m_b));
                        m_dbz = 1'b0;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc/in_ready",    32'(in_ready),    32'(m_phase == 0));
            check("cyc/out_valid",   32'(out_valid),   32'(m_phase == 2));
            check("cyc/quotient",    32'(quotient),    32'(m_q));
            check("cyc/remainder",   32'(remainder),   32'(m_r));
            check("cyc/div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    // Runs one operation from a negedge; hold > 0 stalls the result and pokes in_valid meanwhile.
    task automatic run_op(input string nm, input int av, input int bv, input int expq,
                          input int expr, input int expdbz, input int explat, input int hold);
        int t;
        int c0;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check({nm, "/ready_timeout"}, 32'(in_ready), 32'd1);
        a = W'(av);
        b = W'(bv);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        c0 = cyc;
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        check({nm, "/latency"},     32'(cyc - c0),    32'(explat));
        check({nm, "/quotient"},    32'(quotient),    32'(expq));
        check({nm, "/remainder"},   32'(remainder),   32'(expr));
        check({nm, "/div_by_zero"}, 32'(div_by_zero), 32'(expdbz));
        if (hold > 0) begin
            a = 4'd3;
            b = 4'd1;
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                @(negedge clk);
            end
            in_valid = 1'b0;
            check({nm, "/stall_in_ready"}, 32'(in_ready),  32'd0);
            check({nm, "/stall_valid"},    32'(out_valid), 32'd1);
            check({nm, "/stall_quotient"}, 32'(quotient),  32'(expq));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, "/ready_after"}, 32'(in_ready),  32'd1);
        check({nm, "/valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset/in_ready",    32'(in_ready),    32'd1);
        check("reset/out_valid",   32'(out_valid),   32'd0);
        check("reset/quotient",    32'(quotient),    32'd0);
        check("reset/remainder",   32'(remainder),   32'd0);
        check("reset/div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_op("7/2",  7,  2, 32'h38, 0, 0, LAT, 0);
        run_op("1/3",  1,  3, 32'h05, 1, 0, LAT, 0);
        run_op("2/3",  2,  3, RND ? 32'h0B : 32'h0A, 2, 0, LAT, 0);
        run_op("15/1", 15, 1, 32'hF0, 0, 0, LAT, 0);
        run_op("0/9",  0,  9, 32'h00, 0, 0, LAT, 0);
        run_op("6/0",  6,  0, 32'hFF, 6, 1, 0,   0);
        run_op("5/2",  5,  2, 32'h28, 0, 0, LAT, 5);

        // Abort an operation three cycles into its run.
        a = 4'd13;
        b = 4'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/in_ready",  32'(in_ready),  32'd1);
        check("abort/quotient",  32'(quotient),  32'd0);
        @(negedge clk);

        run_op("9/4", 9, 4, 32'h24, 0, 0, LAT, 0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
